// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default sizing plus the Gray/binary helpers
// used by both the read-side and write-side pointer controllers.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 4;
  localparam int PTR_W           = FIFO_ADDR_WIDTH + 1;

  // Helpers work on a wide container; callers size-cast to their pointer width.
  localparam int CODE_W = 32;
  typedef logic [CODE_W-1:0] code_t;

  function automatic code_t bin2gray(input code_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic code_t gray2bin(input code_t gray);
    code_t bin;
    bin[CODE_W-1] = gray[CODE_W-1];
    for (int i = CODE_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/rd_ctrl_gen_gray2bin.sv
// Combinational Gray-to-binary converter of parametrised width; bit i of the
// result is the XOR of Gray bits [WIDTH-1:i].
module gray2bin
  import fifo_pkg::*;
#(
  parameter int WIDTH = PTR_W
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  assign o_bin = WIDTH'(fifo_pkg::gray2bin(code_t'(i_gray)));

endmodule

// File: rtl/rd_ctrl_gen.sv
// Read-side async-FIFO controller: binary RAM address, registered Gray read
// pointer, registered empty/almost-empty/level, and underflow detection.
module rd_ctrl_gen
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH      = FIFO_ADDR_WIDTH,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  rd_inc,
  input  logic                  rd_err_clr,
  input  logic [ADDR_WIDTH:0]   sync_wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_empty,
  output logic                  rd_almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  rd_underflow,
  output logic                  rd_underflow_sticky
);

  localparam int              PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0]   AE_TH = PW'(ALMOST_EMPTY_TH);

  logic [PW-1:0] r_ptr_bin;
  logic [PW-1:0] r_ptr_gray;
  logic          r_empty;
  logic          r_almost_empty;
  logic [PW-1:0] r_level;
  logic          r_underflow;
  logic          r_underflow_sticky;

  logic          w_rd_acc;
  logic          w_underflow;
  logic [PW-1:0] w_ptr_bin_nxt;
  logic [PW-1:0] w_ptr_gray_nxt;
  logic [PW-1:0] w_wr_ptr_bin;
  logic [PW-1:0] w_level_nxt;

  gray2bin #(.WIDTH(PW)) u_wr_g2b (
    .i_gray (sync_wr_ptr_gray),
    .o_bin  (w_wr_ptr_bin)
  );

  // Accept is gated by the registered flag so a read can never pass the last
  // entry; the flag already accounts for any read accepted on the prior edge.
  assign w_rd_acc       = rd_inc & ~r_empty;
  assign w_underflow    = rd_inc &  r_empty;
  assign w_ptr_bin_nxt  = r_ptr_bin + PW'(w_rd_acc);
  assign w_ptr_gray_nxt = PW'(bin2gray(code_t'(w_ptr_bin_nxt)));
  // Modular subtraction keeps the level right across the pointer wrap.
  assign w_level_nxt    = w_wr_ptr_bin - w_ptr_bin_nxt;

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_ptr_bin          <= '0;
      r_ptr_gray         <= '0;
      r_empty            <= 1'b1;
      r_almost_empty     <= 1'b1;
      r_level            <= '0;
      r_underflow        <= 1'b0;
      r_underflow_sticky <= 1'b0;
    end else begin
      r_ptr_bin      <= w_ptr_bin_nxt;
      r_ptr_gray     <= w_ptr_gray_nxt;
      r_empty        <= (w_ptr_gray_nxt == sync_wr_ptr_gray);
      r_almost_empty <= (w_level_nxt <= AE_TH);
      r_level        <= w_level_nxt;
      r_underflow    <= w_underflow;
      // A new underflow outranks a simultaneous clear.
      if (w_underflow) begin
        r_underflow_sticky <= 1'b1;
      end else if (rd_err_clr) begin
        r_underflow_sticky <= 1'b0;
      end
    end
  end

  assign rd_ptr_gray         = r_ptr_gray;
  assign rd_addr             = r_ptr_bin[ADDR_WIDTH-1:0];
  assign rd_empty            = r_empty;
  assign rd_almost_empty     = r_almost_empty;
  assign rd_level            = r_level;
  assign rd_underflow        = r_underflow;
  assign rd_underflow_sticky = r_underflow_sticky;

endmodule

// File: tb/tb_rd_ctrl_gen.sv
// Self-checking bench for rd_ctrl_gen: directed scenarios plus a random phase,
// all compared against a counter-based reference model of the FIFO read side.
module tb_rd_ctrl_gen;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int PMOD  = 32;
  localparam int AE_TH = 2;

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic          rd_inc;
  logic          rd_err_clr;
  logic [AW:0]   sync_wr_ptr_gray;
  logic [AW:0]   rd_ptr_gray;
  logic [AW-1:0] rd_addr;
  logic          rd_empty;
  logic          rd_almost_empty;
  logic [AW:0]   rd_level;
  logic          rd_underflow;
  logic          rd_underflow_sticky;

  int total = 0;
  int bad   = 0;

  // Reference model: read count and write count as plain integers mod 2*DEPTH.
  int m_rd, m_wr, m_level;
  bit m_empty, m_ae, m_under, m_sticky;

  rd_ctrl_gen #(.ADDR_WIDTH(AW), .ALMOST_EMPTY_TH(AE_TH)) dut (
    .rd_clk              (rd_clk),
    .rd_rst              (rd_rst),
    .rd_inc              (rd_inc),
    .rd_err_clr          (rd_err_clr),
    .sync_wr_ptr_gray    (sync_wr_ptr_gray),
    .rd_ptr_gray         (rd_ptr_gray),
    .rd_addr             (rd_addr),
    .rd_empty            (rd_empty),
    .rd_almost_empty     (rd_almost_empty),
    .rd_level            (rd_level),
    .rd_underflow        (rd_underflow),
    .rd_underflow_sticky (rd_underflow_sticky)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int gray_of(input int v);
    return (v ^ (v >> 1)) % PMOD;
  endfunction

  task automatic drive_wr();
    sync_wr_ptr_gray = 5'(gray_of(m_wr));
  endtask

  task automatic model_reset();
    m_rd = 0; m_level = 0; m_empty = 1; m_ae = 1; m_under = 0; m_sticky = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".gray"},   32'(rd_ptr_gray),         32'(gray_of(m_rd)));
    check({tag, ".addr"},   32'(rd_addr),             32'(m_rd % DEPTH));
    check({tag, ".empty"},  32'(rd_empty),            32'(m_empty));
    check({tag, ".ae"},     32'(rd_almost_empty),     32'(m_ae));
    check({tag, ".level"},  32'(rd_level),            32'(m_level));
    check({tag, ".uf"},     32'(rd_underflow),        32'(m_under));
    check({tag, ".sticky"}, 32'(rd_underflow_sticky), 32'(m_sticky));
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then compare every output shortly after the edge.
  task automatic tick(input string tag);
    @(posedge rd_clk);
    m_under = rd_inc && m_empty;
    if (rd_inc && !m_empty) m_rd = (m_rd + 1) % PMOD;
    if (m_under) m_sticky = 1;
    else if (rd_err_clr) m_sticky = 0;
    m_level = (m_wr - m_rd + PMOD) % PMOD;
    m_empty = (m_level == 0);
    m_ae    = (m_level <= AE_TH);
    #1;
    check_all(tag);
  endtask

  task automatic write_steps(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      m_wr = (m_wr + 1) % PMOD;
      drive_wr();
      tick(tag);
    end
  endtask

  task automatic pulse_reset();
    @(negedge rd_clk);
    rd_rst = 1'b1; rd_inc = 1'b0; rd_err_clr = 1'b0;
    m_wr = 0; drive_wr();
    model_reset();
    #1;
    check_all("rst_pulse");
    @(negedge rd_clk);
    rd_rst = 1'b0;
  endtask

  initial begin
    rd_rst = 1'b1; rd_inc = 1'b0; rd_err_clr = 1'b0;
    m_wr = 0; drive_wr();
    model_reset();

    // 1. Reset held with rd_inc toggling.
    #1;
    check_all("rst0");
    for (int i = 0; i < 4; i++) begin
      @(negedge rd_clk);
      rd_inc = ~rd_inc;
      @(posedge rd_clk);
      #1;
      check_all("rst_hold");
    end
    check("rst.gray_const", 32'(rd_ptr_gray), 32'h0);
    @(negedge rd_clk);
    rd_rst = 1'b0; rd_inc = 1'b0;

    // 2. Fill to 3 then drain.
    m_wr = 3; drive_wr();
    tick("fill3");
    check("fill3.level", 32'(rd_level), 32'd3);
    check("fill3.empty", 32'(rd_empty), 32'd0);
    check("fill3.ae",    32'(rd_almost_empty), 32'd0);
    rd_inc = 1'b1;
    tick("drain1");
    check("drain1.level", 32'(rd_level), 32'd2);
    check("drain1.ae",    32'(rd_almost_empty), 32'd1);
    tick("drain2");
    tick("drain3");
    check("drain3.empty", 32'(rd_empty), 32'd1);
    check("drain3.addr",  32'(rd_addr), 32'd3);
    check("drain3.gray",  32'(rd_ptr_gray), 32'h02);

    // 3. Underflow pulse, set-beats-clear, clear alone.
    tick("uf");
    check("uf.pulse",  32'(rd_underflow), 32'd1);
    check("uf.sticky", 32'(rd_underflow_sticky), 32'd1);
    check("uf.addr",   32'(rd_addr), 32'd3);
    rd_inc = 1'b0;
    tick("uf_gap");
    check("uf_gap.pulse", 32'(rd_underflow), 32'd0);
    rd_inc = 1'b1; rd_err_clr = 1'b1;
    tick("uf_setclr");
    check("uf_setclr.sticky", 32'(rd_underflow_sticky), 32'd1);
    rd_inc = 1'b0;
    tick("uf_clr");
    check("uf_clr.sticky", 32'(rd_underflow_sticky), 32'd0);
    rd_err_clr = 1'b0;

    // 4. Full and wrap, two rounds of 16.
    pulse_reset();
    for (int round = 0; round < 2; round++) begin
      rd_inc = 1'b0;
      write_steps(DEPTH, "fill16");
      check("full.level", 32'(rd_level), 32'd16);
      check("full.empty", 32'(rd_empty), 32'd0);
      rd_inc = 1'b1;
      for (int i = 0; i < DEPTH; i++) tick("read16");
      check("wrap.empty", 32'(rd_empty), 32'd1);
      check("wrap.addr",  32'(rd_addr), 32'd0);
      check("wrap.gray",  32'(rd_ptr_gray), (round == 0) ? 32'h18 : 32'h00);
    end
    rd_inc = 1'b0;

    // 5. Simultaneous accepted read and write at level 5.
    write_steps(5, "to5");
    rd_inc = 1'b1;
    m_wr = (m_wr + 1) % PMOD; drive_wr();
    tick("simul");
    check("simul.level", 32'(rd_level), 32'd5);
    check("simul.empty", 32'(rd_empty), 32'd0);
    check("simul.ae",    32'(rd_almost_empty), 32'd0);
    rd_inc = 1'b0;

    // Random phase.
    for (int c = 0; c < 400; c++) begin
      rd_inc     = 1'($urandom_range(0, 1));
      rd_err_clr = ($urandom_range(0, 7) == 0);
      if ((((m_wr - m_rd + PMOD) % PMOD) < DEPTH) && ($urandom_range(0, 1) == 1))
        m_wr = (m_wr + 1) % PMOD;
      drive_wr();
      tick("rand");
    end
    rd_err_clr = 1'b0;

    // 6. Reset mid-burst from level 8.
    rd_inc = 1'b1;
    for (int i = 0; i < 40 && !m_empty; i++) tick("drain_all");
    check("drain_all.done", 32'(rd_empty), 32'd1);
    rd_inc = 1'b0;
    write_steps(8, "to8");
    check("lvl8.level", 32'(rd_level), 32'd8);
    rd_inc = 1'b1;
    tick("burst1");
    tick("burst2");
    #2;
    rd_rst = 1'b1;
    #1;
    model_reset();
    check_all("midrst");
    check("midrst.level", 32'(rd_level), 32'd0);
    check("midrst.empty", 32'(rd_empty), 32'd1);
    m_wr = 0; drive_wr();
    @(posedge rd_clk);
    #1;
    check_all("midrst_hold");
    @(negedge rd_clk);
    rd_rst = 1'b0; rd_inc = 1'b0;
    write_steps(2, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
